// File: rtl/cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_rx_pkg
// Brief    : Shared types and default parameters for the BLE command receiver
//            (UART bit receiver state set, byte assembler state set).
// Revision : 1.0 - initial release
// ============================================================================
package cmd_rx_pkg;

  // 50 MHz / 19200 baud
  localparam int BAUD_DIV_DEF = 2604;
  // Inter-byte timeout between high and low byte
  localparam int TMO_CYC_DEF  = 1 << 20;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [0:0] {
    ASM_WAIT_HI = 1'b0,
    ASM_WAIT_LO = 1'b1
  } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_rx_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART bit receiver, LSB first. Two-flop synchronizer on RX,
//            start-bit validation at mid-bit, one-cycle rdy / frm_err pulses
//            coincident with the stop-bit sample. BAUD_DIV must be >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import cmd_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frm_err
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = RX_IDLE;
  localparam logic [1:0] S_START = RX_START;
  localparam logic [1:0] S_DATA  = RX_DATA;
  localparam logic [1:0] S_STOP  = RX_STOP;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  logic w_fall;
  logic w_tick;

  // The previous synchronized value gives a clean falling-edge detect
  assign w_fall = r_rx_prev & ~r_rx_sync;
  // Sample point: the counter has run down to its last cycle
  assign w_tick = (r_cnt <= C_ONE);

  // Synchronize the asynchronous line; all flops idle high like the line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Frame decoder: start validation, 8 data samples, stop check
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= C_HALF;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_rx_sync) begin
              // Line back high at mid-start: glitch, not a frame
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_cnt     <= C_FULL;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_cnt   <= C_FULL;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Result pulses are valid in the stop-sample cycle itself
  assign rdy     = ~rst & (r_state == S_STOP) & w_tick &  r_rx_sync;
  assign frm_err = ~rst & (r_state == S_STOP) & w_tick & ~r_rx_sync;
  assign rx_data = r_shift;

endmodule
`default_nettype wire

// File: rtl/cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : cmd_rx
// Brief    : BLE command receiver. Receives UART bytes and assembles them in
//            pairs {high, low} into a 16-bit command with a ready flag, an
//            inter-byte timeout, and discard of partial commands on errors.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int TMO_CYC  = TMO_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int TMO_W = $clog2(TMO_CYC);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] C_TMO_ONE  = TMO_W'(1);

  localparam logic [0:0] S_WAIT_HI = ASM_WAIT_HI;
  localparam logic [0:0] S_WAIT_LO = ASM_WAIT_LO;

  logic             w_byte_rdy;
  logic [7:0]       w_byte;
  logic             w_frm_err;

  logic [0:0]       r_state;
  logic [7:0]       r_hi;
  logic [TMO_W-1:0] r_tmo;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_rx (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .rdy     (w_byte_rdy),
    .rx_data (w_byte),
    .frm_err (w_frm_err)
  );

  // Byte-pair assembler; completion setting cmd_rdy overrides the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT_HI;
      r_hi      <= '0;
      r_tmo     <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      case (r_state)
        S_WAIT_HI: begin
          if (w_byte_rdy) begin
            // A new command has started; the held one is now stale
            r_hi      <= w_byte;
            r_cmd_rdy <= 1'b0;
            r_tmo     <= '0;
            r_state   <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (w_byte_rdy) begin
            r_cmd     <= {r_hi, w_byte};
            r_cmd_rdy <= 1'b1;
            r_state   <= S_WAIT_HI;
          end else if (w_frm_err || (r_tmo == C_TMO_LAST)) begin
            // Drop the lone high byte; cmd and cmd_rdy are left alone
            r_state <= S_WAIT_HI;
          end else begin
            r_tmo <= r_tmo + C_TMO_ONE;
          end
        end
        default: begin
          r_state <= S_WAIT_HI;
        end
      endcase
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign frm_err = w_frm_err;

endmodule
`default_nettype wire

// File: doc/cmd_rx.md
CMD_RX -- requirements
Module: cmd_rx

Interface
REQ-001 Parameter: BAUD_DIV, default 2604; clock cycles per UART bit (50 MHz / 19200 baud).
REQ-002 Parameter: TMO_CYC, default 2^20; cycles allowed between high and low byte before the partial command is discarded.
REQ-003 Port: clk  input  1  operational clock; the only clock in the block.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: RX  input  1  asynchronous serial line from the BLE module; idles high.
REQ-006 Port: clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-007 Port: cmd  output  16  last complete command, {high byte, low byte}.
REQ-008 Port: cmd_rdy  output  1  level; high while an unacknowledged command is held in cmd.
REQ-009 Port: frm_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer; both flops reset to 1; all decoding SHALL use the synchronized value.
REQ-011 The bit receiver SHALL have the states IDLE, START, DATA and STOP, and SHALL decode 8N1 frames, LSB first.
REQ-012 IDLE->START on a synchronized falling edge; the baud counter loads BAUD_DIV/2 (integer divide).
REQ-013 At the START mid-bit sample: RX=1 is a false start and returns to IDLE with no output; RX=0 moves to DATA with the counter reloaded to BAUD_DIV.
REQ-014 DATA SHALL sample 8 bits, one every BAUD_DIV cycles, shifting into an 8-bit register; it moves to STOP after the 8th sample.
REQ-015 At the STOP sample: RX=1 produces an internal byte_rdy pulse (1 cycle, with the byte); RX=0 pulses frm_err and drops the byte; both paths return to IDLE.
REQ-016 A new falling edge SHALL be accepted in the cycle after the return to IDLE; back-to-back frames SHALL NOT lose bytes.
REQ-017 The assembler SHALL have the states WAIT_HI and WAIT_LO, with reset state WAIT_HI.
REQ-018 WAIT_HI + byte_rdy: the byte is stored as the high byte; cmd_rdy clears in that cycle; the timeout counter clears; go to WAIT_LO.
REQ-019 WAIT_LO + byte_rdy: cmd <= {high byte, byte} and cmd_rdy <= 1 on the next edge; go to WAIT_HI.
REQ-020 Latency: cmd and cmd_rdy SHALL be valid 1 cycle after the low-byte stop-bit sample.
REQ-021 WAIT_LO timeout: once the counter reaches TMO_CYC-1 with no byte, the high byte is discarded and the state returns to WAIT_HI; cmd and cmd_rdy are unchanged.
REQ-022 WAIT_LO + frm_err: the partial command is discarded and the state returns to WAIT_HI.
REQ-023 cmd SHALL change only on command completion (REQ-019); it holds its value through partial receptions and errors.
REQ-024 clr_cmd_rdy SHALL clear cmd_rdy on the next edge; if it coincides with completion, the set wins.
REQ-025 clr_cmd_rdy while cmd_rdy=0 SHALL have no effect.

Reset
REQ-026 rst SHALL force both FSMs to IDLE/WAIT_HI and set cmd=16'h0000, cmd_rdy=0, frm_err=0; all counters clear.
REQ-027 rst mid-frame SHALL abort the frame; the next falling edge after rst deasserts SHALL start a clean frame.

Structure
REQ-028 A shared package SHALL hold the rx_state_t and asm_state_t enums, plus the BAUD_DIV and TMO_CYC defaults.
REQ-029 The bit receiver SHALL be the sub-module uart_rx (clk, rst, RX, rdy, rx_data, frm_err); cmd_rx instantiates it plus the assembler.

Verification (BAUD_DIV=16, TMO_CYC=1000)
REQ-030 Frames 8'hA5 then 8'h3C -> cmd=16'hA53C, cmd_rdy=1 one cycle after the 2nd stop sample; then clr_cmd_rdy -> cmd_rdy=0.
REQ-031 Low pulse of 4 cycles on RX (glitch) -> no byte, no frm_err; a following frame 8'h12,8'h34 -> cmd=16'h1234.
REQ-032 8'hFF then 8'h00 with the stop bit driven 0 -> frm_err pulse of 1 cycle; cmd keeps its prior value; the next pair 8'h01,8'h02 -> cmd=16'h0102.
REQ-033 8'h55, then idle for 1200 cycles, then 8'h66,8'h77 -> cmd=16'h6677, never 16'h5566.
REQ-034 clr_cmd_rdy asserted in the cycle cmd_rdy is set -> cmd_rdy=1; while holding 16'hA53C, a new high byte 8'h0F -> cmd_rdy=0 with cmd still 16'hA53C.
REQ-035 rst asserted during bit 4 of 8'hC3, then frames 8'h11,8'h22 sent -> cmd=16'h1122; cmd=16'h0000 and cmd_rdy=0 after rst.
